// File: rtl/core_run_controller.sv
// Run/step sequencer for the single-cycle core: produces the datapath clock-enable,
// with debounced single-step, PC breakpoint, self-loop halt and a saturating retire counter.
module core_run_controller #(
  parameter int unsigned PC_W      = 9,
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned DB_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run_sw,
  input  logic             step_btn,
  input  logic             bkpt_en,
  input  logic [PC_W-1:0]  bkpt_pc,
  input  logic [PC_W-1:0]  pc,
  input  logic             cnt_clr,
  output logic             core_en,
  output logic [1:0]       state,
  output logic [1:0]       halt_cause,
  output logic [CNT_W-1:0] instr_count
);

  localparam int unsigned     DB_W    = $clog2(DB_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_STEP = 2'b10,
    S_HALT = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    C_NONE = 2'b00,
    C_BKPT = 2'b01,
    C_LOOP = 2'b10
  } cause_e;

  logic             run_meta_q, run_s_q, run_prev_q;
  logic             step_meta_q, step_s_q;
  logic             step_stable_q, step_stable_d, step_stable_prev_q;
  logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
  state_e           state_q, state_d;
  cause_e           cause_q, cause_d;
  logic             skip_q, skip_d;
  logic             en_d_q;
  logic [PC_W-1:0]  last_pc_q, last_pc_d;
  logic [CNT_W-1:0] instr_count_q, instr_count_d;

  logic run_rise, step_req, bkpt_hit, loop_hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_meta_q         <= 1'b0;
      run_s_q            <= 1'b0;
      run_prev_q         <= 1'b0;
      step_meta_q        <= 1'b0;
      step_s_q           <= 1'b0;
      step_stable_q      <= 1'b0;
      step_stable_prev_q <= 1'b0;
      db_cnt_q           <= '0;
    end else begin
      run_meta_q         <= run_sw;
      run_s_q            <= run_meta_q;
      run_prev_q         <= run_s_q;
      step_meta_q        <= step_btn;
      step_s_q           <= step_meta_q;
      step_stable_q      <= step_stable_d;
      step_stable_prev_q <= step_stable_q;
      db_cnt_q           <= db_cnt_d;
    end
  end

  // Counter only runs while the synchronised button disagrees with the accepted level.
  always_comb begin
    db_cnt_d      = '0;
    step_stable_d = step_stable_q;
    if (step_s_q != step_stable_q) begin
      if (db_cnt_q == DB_LAST) begin
        step_stable_d = step_s_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

  assign run_rise = run_s_q & ~run_prev_q;
  assign step_req = step_stable_q & ~step_stable_prev_q;
  assign bkpt_hit = bkpt_en & (pc == bkpt_pc) & ~skip_q;
  assign loop_hit = en_d_q & (pc == last_pc_q);

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    core_en = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (run_rise)      state_d = S_RUN;
        else if (step_req) state_d = S_STEP;
      end
      S_RUN: begin
        core_en = ~bkpt_hit & ~loop_hit;
        if (!run_s_q) begin
          state_d = S_IDLE;
        end else if (bkpt_hit) begin
          state_d = S_HALT;
          cause_d = C_BKPT;
        end else if (loop_hit) begin
          state_d = S_HALT;
          cause_d = C_LOOP;
        end
      end
      S_STEP: begin
        core_en = 1'b1;
        state_d = S_IDLE;
      end
      S_HALT: begin
        if (run_rise) begin
          state_d = S_RUN;
          cause_d = C_NONE;
        end else if (step_req) begin
          state_d = S_STEP;
          cause_d = C_NONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Breakpoint is masked for the first RUN cycle so resuming at bkpt_pc executes it.
  assign skip_d    = (state_d == S_RUN) && (state_q != S_RUN);
  assign last_pc_d = core_en ? pc : last_pc_q;

  always_comb begin
    instr_count_d = instr_count_q;
    if (cnt_clr) begin
      instr_count_d = '0;
    end else if (core_en && !(&instr_count_q)) begin
      instr_count_d = instr_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      cause_q       <= C_NONE;
      skip_q        <= 1'b0;
      en_d_q        <= 1'b0;
      last_pc_q     <= '0;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cause_q       <= cause_d;
      skip_q        <= skip_d;
      en_d_q        <= core_en;
      last_pc_q     <= last_pc_d;
      instr_count_q <= instr_count_d;
    end
  end

  assign state       = state_q;
  assign halt_cause  = cause_q;
  assign instr_count = instr_count_q;

endmodule

// File: tb/tb_core_run_controller.sv
// Bench for core_run_controller: directed scenarios plus random stimulus, checked every
// cycle against a behavioural model of the run/step/halt rules.
module tb_core_run_controller;

  localparam int unsigned PC_W    = 9;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned DB      = 4;
  localparam int unsigned CNT_MAX = 15;

  localparam int unsigned M_IDLE = 0;
  localparam int unsigned M_RUN  = 1;
  localparam int unsigned M_STEP = 2;
  localparam int unsigned M_HALT = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             run_sw, step_btn, bkpt_en, cnt_clr;
  logic [PC_W-1:0]  bkpt_pc, pc;
  logic             core_en;
  logic [1:0]       state, halt_cause;
  logic [CNT_W-1:0] instr_count;

  core_run_controller #(.PC_W(PC_W), .CNT_W(CNT_W), .DB_CYCLES(DB)) dut (
    .clk(clk), .reset(reset), .run_sw(run_sw), .step_btn(step_btn),
    .bkpt_en(bkpt_en), .bkpt_pc(bkpt_pc), .pc(pc), .cnt_clr(cnt_clr),
    .core_en(core_en), .state(state), .halt_cause(halt_cause),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit              rh[3], sh[3];     // raw input samples at the last three edges, [0] newest
  bit              m_stable, m_stable_prev;
  int unsigned     m_mis;            // consecutive edges the button disagreed with accepted level
  int unsigned     m_mode, m_cause, m_count;
  bit              m_skip, m_en_prev;
  logic [PC_W-1:0] m_last_pc;

  function automatic bit m_bk();
    return bkpt_en && (pc == bkpt_pc) && !m_skip;
  endfunction

  function automatic bit m_lp();
    return m_en_prev && (pc == m_last_pc);
  endfunction

  function automatic bit m_en();
    return (m_mode == M_RUN && !m_bk() && !m_lp()) || (m_mode == M_STEP);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 3; i++) begin rh[i] = 0; sh[i] = 0; end
    m_stable = 0; m_stable_prev = 0; m_mis = 0;
    m_mode = M_IDLE; m_cause = 0; m_count = 0;
    m_skip = 0; m_en_prev = 0; m_last_pc = '0;
  endtask

  task automatic m_step();
    bit en, bk, lp, run_s, rise, sreq;
    int unsigned nm, nc;
    en = m_en(); bk = m_bk(); lp = m_lp();
    run_s = rh[1];
    rise  = run_s && !rh[2];
    sreq  = m_stable && !m_stable_prev;
    nm = m_mode; nc = m_cause;
    if (m_mode == M_IDLE) begin
      if (rise) nm = M_RUN; else if (sreq) nm = M_STEP;
    end else if (m_mode == M_RUN) begin
      if (!run_s) nm = M_IDLE;
      else if (bk) begin nm = M_HALT; nc = 1; end
      else if (lp) begin nm = M_HALT; nc = 2; end
    end else if (m_mode == M_STEP) begin
      nm = M_IDLE;
    end else begin
      if (rise) begin nm = M_RUN; nc = 0; end
      else if (sreq) begin nm = M_STEP; nc = 0; end
    end
    if (cnt_clr) m_count = 0;
    else if (en && m_count < CNT_MAX) m_count++;
    if (en) m_last_pc = pc;
    m_en_prev = en;
    m_skip = (nm == M_RUN) && (m_mode != M_RUN);
    m_stable_prev = m_stable;
    if (sh[1] != m_stable) begin
      m_mis++;
      if (m_mis == DB) begin m_stable = sh[1]; m_mis = 0; end
    end else begin
      m_mis = 0;
    end
    rh[2] = rh[1]; rh[1] = rh[0]; rh[0] = run_sw;
    sh[2] = sh[1]; sh[1] = sh[0]; sh[0] = step_btn;
    m_mode = nm; m_cause = nc;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) m_reset(); else m_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  bit en_last = 0;
  initial begin
    bit e;
    forever begin
      @(negedge clk);
      e = m_en();
      check("core_en", core_en, e);
      check("state", state, m_mode);
      check("halt_cause", halt_cause, m_cause);
      check("instr_count", instr_count, m_count);
      en_last = e;
    end
  end

  // ---------------- stimulus ----------------
  int unsigned     pc_mode = 0;      // 0 hold, 1 +4 per retired instr, 2 +4 until stick_pc
  logic [PC_W-1:0] stick_pc = '0;

  task automatic cyc();
    @(posedge clk);
    #1;
    if (en_last && (pc_mode == 1 || (pc_mode == 2 && pc != stick_pc))) pc = pc + 9'd4;
    @(negedge clk);
    #1;
  endtask

  task automatic wait_state(input int unsigned want, input int unsigned budget, input string name);
    for (int i = 0; i < int'(budget); i++) begin
      if (state == 2'(want)) break;
      cyc();
    end
    check(name, state, want);
  endtask

  initial begin
    int unsigned pulses;
    reset = 1'b0; run_sw = 0; step_btn = 0; bkpt_en = 0; cnt_clr = 0;
    bkpt_pc = '0; pc = '0;
    repeat (3) cyc();
    reset = 1'b1;
    repeat (20) cyc();
    check("lit_idle_state", state, 0);
    check("lit_idle_en", core_en, 0);
    check("lit_idle_cnt", instr_count, 0);

    // bouncing press: one pulse only
    step_btn = 1; cyc(); step_btn = 0; cyc(); step_btn = 1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin cyc(); if (core_en) pulses++; end
    check("lit_bounce_pulses", pulses, 1);
    check("lit_bounce_cnt", instr_count, 1);
    check("lit_bounce_state", state, 0);
    step_btn = 0;
    repeat (15) cyc();

    // clean press: pulse in the cycle after edge 7
    step_btn = 1;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      if (k == 6) check("lit_step_e6_en", core_en, 0);
      if (k == 7) begin
        check("lit_step_e7_en", core_en, 1);
        check("lit_step_e7_state", state, 2);
      end
      if (k == 8) check("lit_step_e8_state", state, 0);
    end
    check("lit_step_cnt", instr_count, 2);
    step_btn = 0;
    repeat (15) cyc();

    // breakpoint halt and resume
    cnt_clr = 1; cyc(); cnt_clr = 0;
    pc = '0; bkpt_pc = 9'h010; bkpt_en = 1; pc_mode = 1; run_sw = 1;
    wait_state(M_HALT, 40, "bkpt_reach_halt");
    check("lit_bkpt_cause", halt_cause, 1);
    check("lit_bkpt_en", core_en, 0);
    check("lit_bkpt_cnt", instr_count, 4);
    check("lit_bkpt_model_cnt", m_count, 4);
    run_sw = 0;
    repeat (4) cyc();
    check("lit_halt_hold", state, 3);
    run_sw = 1;
    wait_state(M_RUN, 10, "bkpt_resume_run");
    check("lit_resume_en", core_en, 1);
    check("lit_resume_cause", halt_cause, 0);
    cyc();
    check("lit_resume_cnt", instr_count, 5);
    run_sw = 0; bkpt_en = 0;
    repeat (6) cyc();

    // self-loop halt
    cnt_clr = 1; cyc(); cnt_clr = 0;
    pc = 9'h018; stick_pc = 9'h020; pc_mode = 2; run_sw = 1;
    wait_state(M_HALT, 20, "loop_reach_halt");
    check("lit_loop_cause", halt_cause, 2);
    check("lit_loop_cnt", instr_count, 3);
    run_sw = 0;
    repeat (6) cyc();

    // saturation and clear while enabled
    pc = 9'h040; pc_mode = 1; run_sw = 1;
    repeat (25) cyc();
    check("lit_sat_cnt", instr_count, 15);
    check("lit_sat_en", core_en, 1);
    cnt_clr = 1; cyc(); cnt_clr = 0;
    check("lit_clr_cnt", instr_count, 0);

    // asynchronous reset mid-RUN
    repeat (3) cyc();
    #2 reset = 1'b0;
    #1;
    check("lit_arst_en", core_en, 0);
    check("lit_arst_state", state, 0);
    check("lit_arst_cause", halt_cause, 0);
    check("lit_arst_cnt", instr_count, 0);
    cyc(); cyc();
    reset = 1'b1; run_sw = 0;
    cyc();

    // random phase
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(39) == 0) run_sw = ~run_sw;
      if ($urandom_range(14) == 0) step_btn = ~step_btn;
      if ($urandom_range(49) == 0) begin
        bkpt_en = ~bkpt_en;
        bkpt_pc = 9'($urandom_range(31) * 4);
      end
      if ($urandom_range(29) == 0) pc = 9'($urandom_range(31) * 4);
      if ($urandom_range(24) == 0) begin
        pc_mode = (pc_mode == 1) ? 2 : 1;
        stick_pc = 9'($urandom_range(127) * 4);
      end
      cnt_clr = ($urandom_range(59) == 0);
      reset = ($urandom_range(499) != 0);
      cyc();
    end
    reset = 1'b1;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
